fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the cpu2 core. It owns the program counter, drives `linenumber` into the combinational program ROM, and captures the returned 8-bit instruction into an instruction register. The register is presented to the decoder through a valid/ready handshake. Taken-branch redirects from execute (JNZ and similar) retarget the PC and flush the held instruction.

## Interface
- `ADDR_W`, default 8: PC / `linenumber` width.
- `INSTR_W`, default 8: instruction width.
- `PROG_DEPTH`, default 65: number of valid ROM words. Addresses run 0..PROG_DEPTH-1.

- `clk`  in  1  single clock. All state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `linenumber`  out  ADDR_W  ROM address; equals current PC.
- `rom_data`  in  INSTR_W  ROM word for `linenumber`, valid in the same cycle (combinational ROM).
- `instr`  out  INSTR_W  instruction register to the decoder.
- `instr_pc`  out  ADDR_W  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr_ready`  in  1  decoder accepts `instr` this cycle.
- `branch_valid`  in  1  redirect request from execute, one-cycle pulse.
- `branch_target`  in  ADDR_W  redirect address.
- `halted`  out  1  fetch stopped on a HALT word (see Configuration).

## Operation
- States:
  - FETCH: normal operation.
  - HALT: exists only with the macro.
- Load condition in FETCH: `load = !instr_valid || instr_ready`. On `load`:
  - `instr <= rom_data`
  - `instr_pc <= pc`
  - `instr_valid <= 1`
  - `pc <= next(pc)`
- Stall: when `instr_valid && !instr_ready`, `pc`, `instr`, `instr_pc` and `instr_valid` all hold.
- `next(pc)` is `pc+1`, or 0 when `pc == PROG_DEPTH-1` (wrap). Arithmetic is unsigned ADDR_W; no carry out.
- Redirect (`branch_valid=1`) has priority over load and stall:
  - `pc <= branch_target`
  - `instr_valid <= 0`; the held instruction is discarded even if `instr_ready=1` in that cycle.
  - `branch_target >= PROG_DEPTH` loads 0.
- Redirect during a stall: the stalled instruction is dropped and the decoder sees `instr_valid` fall.
- Back-to-back redirects: the last one wins. Each redirect restarts the sequence.

## Timing
- Reset values (asynchronous, while `rst=0`):
  - `pc = 0`, so `linenumber = 0`
  - `instr = 8'h00` (NOP)
  - `instr_pc = 0`
  - `instr_valid = 0`
  - `halted = 0`
  - state FETCH
- First posedge after reset release: loads ROM[0]. `instr_valid=1` from cycle 1.
- Throughput: one instruction per cycle while `instr_ready=1`.
- Fetch latency: PC to valid `instr` is 1 cycle.
- Redirect at edge N:
  - `linenumber = target` after edge N.
  - `instr = ROM[target]` valid after edge N+1; 1 bubble cycle.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values. No pending redirect survives.

## Configuration
- Macro: `FETCH_HALT_EN`.
- Defined:
  - Fetching `rom_data == 8'hFF` loads nothing and holds `pc` at the HALT address.
  - State goes to HALT and `halted <= 1`.
  - Any valid `instr` still held drains normally through the handshake.
  - In HALT, `branch_valid` is ignored. Only reset exits.
- Undefined:
  - `8'hFF` is an ordinary instruction.
  - `halted` is tied 0.
  - There is no HALT state.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_W` and `ADDR_W` constants
  - opcode field positions ([7:4] opcode, [3:2] dest, [1:0] src/imm, [3:0] jump target)
  - opcode localparams (MOV, ADD, NOT, INC, CMP, JNZ)
  - `NOP_WORD = 8'h00`
  - `HALT_WORD = 8'hFF`
  - the fetch state enum
- One sub-module, `fetch_pc_next`: combinational next-PC (increment, wrap at PROG_DEPTH, redirect mux, out-of-range clamp).
- The handshake and register logic stays in `fetch_unit`.

## Test plan
- **Sequential fetch:** reset, ROM = {00,8B,86,19,34}, `instr_ready=1` → `instr` = 00,8B,86,19,34 on cycles 1-5; `instr_pc` = 0..4.
- **Stall:** deassert `instr_ready` for 3 cycles while `instr=8B` → `instr`, `instr_pc=1`, `linenumber=2` all hold; resumes with 86 on the cycle after `instr_ready` returns.
- **Redirect:** `branch_valid=1`, `target=4` at cycle 6 with `instr_ready=1` → one cycle of `instr_valid=0`, then `instr=ROM[4]`, `instr_pc=4`. The same pulse during a stall also drops the stalled word.
- **Wrap and clamp:** run to `pc=64` → next `linenumber=0`. `branch_target=70` → `linenumber=0`.
- **Halt, FETCH_HALT_EN defined:** ROM[3]=FF → after ROM[2] drains, `halted=1`, `linenumber=3` stays, and `branch_valid` has no effect. With the macro undefined, FF appears as `instr` with `halted=0`.
- **Async reset:** drop `rst` mid-cycle during a stall → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the cpu2 core.
//   - ADDR_W / INSTR_W : default PC and instruction widths
//   - instruction field positions and opcode values
//   - NOP_WORD (reset contents of the instruction register), HALT_WORD
//   - fetch_state_e : fetch FSM states (HALT only used with FETCH_HALT_EN)
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  // Instruction field positions
  localparam int OPC_HI  = 7;
  localparam int OPC_LO  = 4;
  localparam int DST_HI  = 3;
  localparam int DST_LO  = 2;
  localparam int SRC_HI  = 1;
  localparam int SRC_LO  = 0;
  localparam int JTGT_HI = 3;
  localparam int JTGT_LO = 0;

  // Opcodes ([7:4])
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_JNZ = 4'h6;

  localparam logic [7:0] NOP_WORD  = 8'h00;
  localparam logic [7:0] HALT_WORD = 8'hFF;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-PC selection.
//   pc_i         current PC
//   advance_i    an instruction is being loaded this cycle, step the PC
//   redirect_i   taken redirect this cycle (highest priority)
//   target_i     redirect address; targets >= PROG_DEPTH map to 0
//   pc_next_o    PC for the next cycle
module fetch_pc_next #(
  parameter int ADDR_W     = 8,
  parameter int PROG_DEPTH = 65
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              advance_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  // One extra bit so PROG_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(PROG_DEPTH - 1);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt_clamped;

  always_comb begin
    pc_inc      = (pc_i == LAST) ? '0 : pc_i + ADDR_W'(1);
    tgt_clamped = ({1'b0, target_i} >= DEPTH_X) ? '0 : target_i;
    if (redirect_i)     pc_next_o = tgt_clamped;
    else if (advance_i) pc_next_o = pc_inc;
    else                pc_next_o = pc_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the cpu2 core.
// Owns the PC, addresses the combinational program ROM through linenumber
// and captures the returned word into an instruction register handed to
// the decoder over a valid/ready handshake. Redirects from execute
// retarget the PC and discard the held instruction.
// Optional feature macro: FETCH_HALT_EN (stop fetching on HALT_WORD).
//   clk, rst         clock, asynchronous active-low reset
//   linenumber       ROM address (current PC)
//   rom_data         ROM word for linenumber, same cycle
//   instr/instr_pc   instruction register and its fetch address
//   instr_valid      instr holds an unconsumed instruction
//   instr_ready      decoder accepts instr this cycle
//   branch_valid     redirect pulse, branch_target = new PC
//   halted           fetch stopped on HALT_WORD (0 without FETCH_HALT_EN)
module fetch_unit #(
  parameter int ADDR_W     = cpu_pkg::ADDR_W,
  parameter int INSTR_W    = cpu_pkg::INSTR_W,
  parameter int PROG_DEPTH = 65
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  linenumber,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               vld_q, vld_d;
  logic               load, advance, redirect;

`ifdef FETCH_HALT_EN
  fetch_state_e state_q, state_d;
  logic         halted_q, halted_d;
  logic         halt_hit;
`endif

  fetch_pc_next #(
    .ADDR_W     (ADDR_W),
    .PROG_DEPTH (PROG_DEPTH)
  ) u_pc_next (
    .pc_i       (pc_q),
    .advance_i  (advance),
    .redirect_i (redirect),
    .target_i   (branch_target),
    .pc_next_o  (pc_d)
  );

  always_comb begin
    load     = !vld_q || instr_ready;
    redirect = branch_valid;
    advance  = load;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    vld_d    = vld_q;
`ifdef FETCH_HALT_EN
    state_d  = state_q;
    halted_d = halted_q;
    halt_hit = 1'b0;
    if (state_q == HALT) begin
      // Frozen: only let the last held instruction drain.
      redirect = 1'b0;
      advance  = 1'b0;
      vld_d    = vld_q && !instr_ready;
    end else begin
      halt_hit = load && (rom_data == INSTR_W'(HALT_WORD));
      advance  = load && !halt_hit;
      // A simultaneous redirect wins: we never really fetched the HALT word.
      if (halt_hit && !branch_valid) begin
        state_d  = HALT;
        halted_d = 1'b1;
        vld_d    = 1'b0;
      end
    end
`endif
    if (redirect) begin
      vld_d = 1'b0;
    end else if (advance) begin
      instr_d = rom_data;
      ipc_d   = pc_q;
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP_WORD);
      ipc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign linenumber  = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk, rst;
  logic [7:0] linenumber, rom_data, instr, instr_pc, branch_target;
  logic       instr_valid, instr_ready, branch_valid, halted;

  logic [7:0] rom [0:255];
  assign rom_data = rom[linenumber];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.ADDR_W(8), .INSTR_W(8), .PROG_DEPTH(65)) dut (
    .clk           (clk),
    .rst           (rst),
    .linenumber    (linenumber),
    .rom_data      (rom_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rdy;
    logic       bv;
    logic [7:0] bt;
    logic       ev;
    logic [7:0] ei;
    logic [7:0] ep;
    logic [7:0] el;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic rdy, logic bv, logic [7:0] bt,
                              logic ev, logic [7:0] ei, logic [7:0] ep, logic [7:0] el);
    vec_t v;
    v.rdy = rdy; v.bv = bv; v.bt = bt;
    v.ev = ev; v.ei = ei; v.ep = ep; v.el = el;
    vt.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    instr_ready = 1'b0; branch_valid = 1'b0; branch_target = 8'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_line"},   32'(linenumber), 32'd0);
    check({tag, "_instr"},  32'(instr), 32'h00);
    check({tag, "_ipc"},    32'(instr_pc), 32'd0);
    check({tag, "_valid"},  32'(instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = (i >= 5 && i < 255) ? 8'(i) : 8'h00;
    rom[0] = 8'h00; rom[1] = 8'h8B; rom[2] = 8'h86; rom[3] = 8'h19; rom[4] = 8'h34;

    //   rdy bv bt    ev  instr  ipc  line
    add(1, 0, 0,     1, 8'h00, 0,  1);   // sequential fetch
    add(1, 0, 0,     1, 8'h8B, 1,  2);
    add(0, 0, 0,     1, 8'h8B, 1,  2);   // stall x3
    add(0, 0, 0,     1, 8'h8B, 1,  2);
    add(0, 0, 0,     1, 8'h8B, 1,  2);
    add(1, 0, 0,     1, 8'h86, 2,  3);   // resume
    add(1, 0, 0,     1, 8'h19, 3,  4);
    add(1, 0, 0,     1, 8'h34, 4,  5);
    add(1, 1, 4,     0, 8'h00, 0,  4);   // redirect, ready=1: bubble
    add(1, 0, 0,     1, 8'h34, 4,  5);
    add(0, 0, 0,     1, 8'h34, 4,  5);   // stall
    add(0, 1, 2,     0, 8'h00, 0,  2);   // redirect during stall drops word
    add(0, 0, 0,     1, 8'h86, 2,  3);
    add(1, 1, 70,    0, 8'h00, 0,  0);   // out-of-range clamp
    add(1, 0, 0,     1, 8'h00, 0,  1);
    add(1, 1, 10,    0, 8'h00, 0, 10);   // back-to-back, last wins
    add(1, 1, 20,    0, 8'h00, 0, 20);
    add(1, 0, 0,     1, 8'h14, 20, 21);
    add(1, 1, 64,    0, 8'h00, 0, 64);   // last valid address
    add(1, 0, 0,     1, 8'h40, 64, 0);   // wrap
    add(1, 0, 0,     1, 8'h00, 0,  1);
    add(1, 1, 65,    0, 8'h00, 0,  0);   // target == depth clamps
    add(1, 0, 0,     1, 8'h00, 0,  1);

    do_reset();
    check_reset_vals("reset");

    for (int i = 0; i < vt.size(); i++) begin
      instr_ready   = vt[i].rdy;
      branch_valid  = vt[i].bv;
      branch_target = vt[i].bt;
      step();
      check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vt[i].ev));
      check($sformatf("v%0d_line", i),  32'(linenumber),  32'(vt[i].el));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'd0);
      if (vt[i].ev) begin
        check($sformatf("v%0d_instr", i), 32'(instr),    32'(vt[i].ei));
        check($sformatf("v%0d_ipc", i),   32'(instr_pc), 32'(vt[i].ep));
      end
    end
    branch_valid = 1'b0;

    // Async reset mid-stall with a redirect pending
    do_reset();
    instr_ready = 1'b1;
    step(); step();                      // instr=8B, line=2
    instr_ready = 1'b0;
    step();
    branch_valid = 1'b1; branch_target = 8'd30;
    #2 rst = 1'b0;
    #1 check_reset_vals("async");
    step();                              // edge while held in reset
    check("async_hold_line", 32'(linenumber), 32'd0);
    #2;
    rst = 1'b1; branch_valid = 1'b0; instr_ready = 1'b1;
    step();
    check("async_rel_instr", 32'(instr), 32'h00);
    check("async_rel_valid", 32'(instr_valid), 32'd1);
    check("async_rel_line",  32'(linenumber), 32'd1);

    // HALT word at address 3
    rom[3] = 8'hFF;
    do_reset();
    instr_ready = 1'b1;
    step(); step(); step();              // 00, 8B, 86
    check("halt_pre_instr", 32'(instr), 32'h86);
    check("halt_pre_line",  32'(linenumber), 32'd3);
    step();
`ifdef FETCH_HALT_EN
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid",  32'(instr_valid), 32'd0);
    check("halt_line",   32'(linenumber), 32'd3);
    branch_valid = 1'b1; branch_target = 8'd0;
    step();
    branch_valid = 1'b0;
    check("halt_br_line",   32'(linenumber), 32'd3);
    check("halt_br_halted", 32'(halted), 32'd1);
    check("halt_br_valid",  32'(instr_valid), 32'd0);
`else
    check("ff_instr",  32'(instr), 32'hFF);
    check("ff_ipc",    32'(instr_pc), 32'd3);
    check("ff_valid",  32'(instr_valid), 32'd1);
    check("ff_halted", 32'(halted), 32'd0);
    check("ff_line",   32'(linenumber), 32'd4);
`endif
    rom[3] = 8'h19;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
